// File: rtl/timer_mc.sv
// timer_mc: CH-channel up/down timer with a shared prescaler behind an APB-lite slave port.
// Define TIMER_MC_IRQ_EN to build the registered per-channel interrupt outputs.
module timer_mc #(
  parameter int WIDTH  = 8,
  parameter int CH     = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [WIDTH-1:0]  pwdata,
  output logic [WIDTH-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CH-1:0]     irq
);
  // Bus handshake: an access completes in the cycle psel&penable is high (no wait states);
  // a write commits at the closing clk edge only when pslverr is low.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4*CH);

  logic                     access;
  logic                     in_range;
  logic                     err;
  logic                     wr;
  logic [3:0]               div_cnt;
  logic [CH-1:0][WIDTH-1:0] ch_rdata;

  assign access   = psel & penable;
  assign in_range = ({1'b0, paddr} < LIMIT);
  assign err      = access & (~in_range | (pwrite & (paddr[1:0] == 2'd3)));
  assign pslverr  = err;
  assign pready   = access;
  assign wr       = access & pwrite & ~err;

  always_comb begin
    prdata = '0;
    if (access && in_range) begin
      for (int c = 0; c < CH; c++) begin
        if (paddr[ADDR_W-1:2] == (ADDR_W-2)'(c)) prdata = ch_rdata[c];
      end
    end
  end

  // Free-running prescaler shared by all channels; enable never resets its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + 4'd1;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam logic [ADDR_W-3:0] IDX = (ADDR_W-2)'(c);

    logic [WIDTH-1:0] tdr;
    logic [WIDTH-1:0] tcnt;
    logic [6:1]       tcr;
    logic [1:0]       tsr;
    logic [WIDTH-1:0] rd;
    logic             hit;
    logic             tick;
    logic             load;
    logic             step;
    logic             ovf_set;
    logic             udf_set;
    logic [1:0]       clr;

    assign hit     = wr && (paddr[ADDR_W-1:2] == IDX);
    assign load    = hit && (paddr[1:0] == 2'd1) && pwdata[0];
    assign step    = tcr[2] & tick & ~load;
    assign ovf_set = step & ~tcr[1] & (tcnt == '1);
    assign udf_set = step &  tcr[1] & (tcnt == '0);
    assign clr     = (hit && (paddr[1:0] == 2'd2)) ? pwdata[1:0] : 2'b00;

    always_comb begin
      tick = 1'b0;
      case (tcr[4:3])
        2'd0: tick = div_cnt[0];
        2'd1: tick = &div_cnt[1:0];
        2'd2: tick = &div_cnt[2:0];
        2'd3: tick = &div_cnt;
        default: tick = 1'b0;
      endcase
    end

    // Load uses the pre-edge TDR, so a TDR write in the same cycle is not seen.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tdr  <= '0;
        tcr  <= '0;
        tsr  <= '0;
        tcnt <= '0;
      end else begin
        if (hit && (paddr[1:0] == 2'd0)) tdr <= pwdata;
        if (hit && (paddr[1:0] == 2'd1)) tcr <= pwdata[6:1];
        if (load)      tcnt <= tdr;
        else if (step) tcnt <= tcr[1] ? tcnt - 1'b1 : tcnt + 1'b1;
        tsr <= (tsr & ~clr) | {udf_set, ovf_set};
      end
    end

    always_comb begin
      rd = '0;
      case (paddr[1:0])
        2'd0: rd = tdr;
        2'd1: rd = WIDTH'({tcr, 1'b0});
        2'd2: rd = WIDTH'(tsr);
        2'd3: rd = tcnt;
        default: rd = '0;
      endcase
    end
    assign ch_rdata[c] = rd;

`ifdef TIMER_MC_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= (tsr[0] & tcr[5]) | (tsr[1] & tcr[6]);
    end
    assign irq[c] = irq_q;
`else
    assign irq[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_timer_mc.sv
// Bench for timer_mc: directed and random APB traffic checked against a register-level model.
module tb_timer_mc;
  localparam int WIDTH  = 8;
  localparam int CH     = 2;
  localparam int ADDR_W = 8;
  localparam int MASK   = (1 << WIDTH) - 1;
`ifdef TIMER_MC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [WIDTH-1:0]  pwdata = '0;
  logic [WIDTH-1:0]  prdata;
  logic              pready;
  logic              pslverr;
  logic [CH-1:0]     irq;

  timer_mc #(.WIDTH(WIDTH), .CH(CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {is_write, pslverr, prdata}
  logic [WIDTH+1:0] exp_q[$];

  // reference model: register contents as plain integers
  int            m_tdr [CH];
  int            m_tcr [CH];
  int            m_tsr [CH];
  int            m_tcnt[CH];
  int            cyc = 0;
  logic [CH-1:0] m_irq = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit bad_access(input int a, input bit w);
    return (a >= 4*CH) || (w && (a % 4 == 3));
  endfunction

  function automatic logic [WIDTH:0] model_read(input int a);
    int c;
    if (a >= 4*CH) return {1'b1, {WIDTH{1'b0}}};
    c = a / 4;
    case (a % 4)
      0: return {1'b0, WIDTH'(m_tdr[c])};
      1: return {1'b0, WIDTH'(m_tcr[c])};
      2: return {1'b0, WIDTH'(m_tsr[c])};
      default: return {1'b0, WIDTH'(m_tcnt[c])};
    endcase
  endfunction

  // model update at each edge, from the bus values the bench is driving
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; m_tcnt[c] = 0;
      end
      cyc = 0;
      m_irq = '0;
    end else begin
      int  a;
      bit  w;
      a = int'(paddr);
      w = psel && penable && pwrite && !bad_access(a, 1'b1);
      for (int c = 0; c < CH; c++) begin
        int per;
        int set;
        int clr;
        m_irq[c] = IRQ_EN && (((m_tsr[c] & 1) != 0 && (m_tcr[c] & 'h20) != 0) ||
                              ((m_tsr[c] & 2) != 0 && (m_tcr[c] & 'h40) != 0));
        per = 2 << ((m_tcr[c] >> 3) & 3);
        set = 0;
        if (w && a == 4*c+1 && (pwdata & 1) != 0) begin
          m_tcnt[c] = m_tdr[c];
        end else if ((m_tcr[c] & 4) != 0 && (cyc % per) == per - 1) begin
          if ((m_tcr[c] & 2) != 0) begin
            if (m_tcnt[c] == 0) set = 2;
            m_tcnt[c] = (m_tcnt[c] - 1) & MASK;
          end else begin
            m_tcnt[c] = (m_tcnt[c] + 1) & MASK;
            if (m_tcnt[c] == 0) set = 1;
          end
        end
        clr = (w && a == 4*c+2) ? int'(pwdata) & 3 : 0;
        m_tsr[c] = (m_tsr[c] & ~clr) | set;
        if (w && a == 4*c)   m_tdr[c] = int'(pwdata);
        if (w && a == 4*c+1) m_tcr[c] = int'(pwdata) & 'h7E;
      end
      cyc++;
    end
  end

  // monitor: pops the scoreboard whenever an access phase is on the bus
  initial forever begin
    logic [WIDTH+1:0] e;
    @(negedge clk);
    if (!rst) begin
      chk("irq", 32'(irq), 32'(m_irq));
      if (psel && penable) begin
        chk("pready", 32'(pready), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: addr %0h with empty queue", paddr);
        end else begin
          e = exp_q.pop_front();
          if (e[WIDTH+1]) chk($sformatf("wr_err@%0h", paddr), 32'(pslverr), 32'(e[WIDTH]));
          else chk($sformatf("rd@%0h", paddr), 32'({pslverr, prdata}), 32'(e[WIDTH:0]));
        end
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input int a, input int d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = ADDR_W'(a); pwdata = WIDTH'(d);
    idle(1);
    penable = 1'b1;
    exp_q.push_back({1'b1, bad_access(a, 1'b1), {WIDTH{1'b0}}});
    idle(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // use_const: expect the given constant instead of the model's view
  task automatic apb_read(input int a, input bit use_const, input int cval, input bit cerr);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ADDR_W'(a);
    idle(1);
    penable = 1'b1;
    if (use_const) exp_q.push_back({1'b0, cerr, WIDTH'(cval)});
    else           exp_q.push_back({1'b0, model_read(a)});
    idle(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int guard;
    idle(3);
    rst = 1'b0;
    idle(1);

    // reset values and address decode
    for (int a = 0; a < 4*CH; a++) apb_read(a, 1'b1, 0, 1'b0);
    apb_read(4*CH, 1'b1, 0, 1'b1);

    // TDR storage and TCNT write protection
    apb_write(0, 'hA5);
    apb_read(0, 1'b1, 'hA5, 1'b0);
    apb_read(4, 1'b1, 0, 1'b0);
    apb_write(3, 'h55);
    apb_read(3, 1'b1, 0, 1'b0);

    // ch0 up-count through the wrap
    apb_write(0, 'hFD);
    apb_write(1, 'h05);
    apb_read(1, 1'b1, 'h04, 1'b0);
    for (int i = 0; i < 8; i++) apb_read(3, 1'b0, 0, 1'b0);
    apb_read(2, 1'b1, 'h01, 1'b0);

    // ch1 down-count through the wrap, then W1C behaviour
    apb_write(4, 'h01);
    apb_write(5, 'h07);
    for (int i = 0; i < 6; i++) apb_read(7, 1'b0, 0, 1'b0);
    apb_read(6, 1'b1, 'h02, 1'b0);
    apb_write(6, 'h00);
    apb_read(6, 1'b1, 'h02, 1'b0);
    apb_write(6, 'h02);
    apb_read(6, 1'b1, 'h00, 1'b0);

    // W1C on the very edge of an OVF wrap: set must win
    apb_write(2, 'h01);
    apb_read(2, 1'b1, 'h00, 1'b0);
    apb_write(0, 'hFF);
    apb_write(1, 'h29);
    guard = 0;
    while ((cyc % 4) != 0 && guard < 8) begin
      idle(1);
      guard++;
    end
    chk("phase_wait", 32'(cyc % 4), 32'd0);
    apb_write(1, 'h2C);
    apb_write(2, 'h01);
    apb_read(2, 1'b1, 'h01, 1'b0);
    apb_read(3, 1'b0, 0, 1'b0);
    idle(3);
    apb_write(2, 'h01);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int a;
      a = $urandom_range(0, 4*CH + 3);
      if ($urandom_range(0, 1) == 1) apb_write(a, $urandom_range(0, MASK));
      else                           apb_read(a, 1'b0, 0, 1'b0);
    end

    // asynchronous reset in the middle of counting
    apb_write(0, 'h80);
    apb_write(1, 'h01);
    apb_read(3, 1'b1, 'h80, 1'b0);
    apb_write(1, 'h24);
    idle(3);
    #2;
    rst = 1'b1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = ADDR_W'(3);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tcnt", 32'(prdata), 32'd0);
    paddr = ADDR_W'(1);
    #1;
    chk("rst_tcr", 32'(prdata), 32'd0);
    psel = 1'b0; penable = 1'b0;
    idle(2);
    rst = 1'b0;
    apb_read(3, 1'b1, 0, 1'b0);
    apb_read(1, 1'b1, 0, 1'b0);
    apb_read(2, 1'b1, 0, 1'b0);
    idle(12);
    apb_read(3, 1'b1, 0, 1'b0);

    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop if the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/timer_mc.md
Name: timer_mc

Overview:
- N-channel, parametrised-width successor to the single-channel 8-bit timer.
- Each channel has a reload register (TDR), control (TCR), W1C status (TSR) and read-only counter (TCNT).
- Channels share one prescaler and one APB-lite slave port driven by the CPU bus model.
- Adds per-channel up/down counting, a self-clearing load command, bus error reporting and optional interrupts.

Parameters:
WIDTH, 8, counter/TDR/bus data width; must be >= 8.
CH, 2, number of channels, 1..16.
ADDR_W, 8, address width; byte-free word map, one register per address.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  1=write, 0=read
paddr  input  ADDR_W  register address
pwdata  input  WIDTH  write data
prdata  output  WIDTH  read data
pready  output  1  transfer complete
pslverr  output  1  transfer error
irq  output  CH  per-channel interrupt

Behaviour:
- One clock domain. rst asynchronously clears all TDR, TCR, TSR, TCNT and the prescaler to 0. irq resets to 0.
- prdata, pready and pslverr are combinational. All three are 0 outside the access phase (psel&penable).
- No wait states: pready = psel&penable.
- Write commits at the clk edge where psel&penable&pwrite&!pslverr.
- Address map, for channel c at base 4*c:
  - +0 TDR (RW)
  - +1 TCR (RW)
  - +2 TSR (RW, W1C)
  - +3 TCNT (RO)
- pslverr=1 in the access phase for:
  - paddr >= 4*CH, where reads return 0;
  - any write to TCNT.
  Erroring writes change no state.
- TCR bits:
  - [0] LOAD: write-1 action, always reads 0.
  - [1] DIR: 0=up, 1=down.
  - [2] EN.
  - [4:3] CKS: tick every 2,4,8,16 clk.
  - [5] OVF_IE, [6] UDF_IE.
  - Upper bits: read 0.
- Prescaler: free-running 4-bit div_cnt, +1 every clk. tick(k) is asserted when div_cnt[k:0] is all ones, for k=CKS.
- Counter update per channel, in priority order:
  - TCR write with LOAD=1: TCNT <= current TDR at that edge. A TDR written in the same cycle does not apply; the old value loads.
  - else EN & tick: TCNT <= TCNT±1, modulo 2^WIDTH.
  - else hold.
- TSR bits: [0] OVF and [1] UDF.
  - OVF sets when an up-count wraps from all-ones to 0.
  - UDF sets when a down-count wraps from 0 to all-ones.
  - Load does not set flags.
- TSR W1C: writing 1 clears the bit; writing 0 has no effect. If a set event and a W1C hit the same edge, the set wins.
- Clearing EN freezes TCNT immediately, with no further increments. The prescaler keeps running, so tick phase is not reset by enable.
- Changing CKS takes effect on the next tick under the new divisor.
- Reset mid-operation aborts counting; all registers read 0 on the first access after release.

Optional Feature:
- TIMER_MC_IRQ_EN defined:
  - irq[c] = (TSR[c].OVF & OVF_IE) | (TSR[c].UDF & UDF_IE).
  - irq is registered: it asserts one clk after the flag sets and deasserts one clk after W1C.
- Undefined:
  - irq tied to 0.
  - TCR[6:5] still read/write as storage bits.

Test Plan:
- Reset, then read all 4*CH addresses -> every prdata=0, pslverr=0. Read address 4*CH -> prdata=0, pslverr=1.
- Ch0: write TDR='hA5, read TDR -> 'hA5. Ch1 TDR stays 0. Write TCNT (addr 3) 'h55 -> pslverr=1, TCNT unchanged.
- Ch0: TDR='hFD, TCR=LOAD|EN with CKS=0 (wdata 'h05), DIR=up:
  - TCNT counts FD,FE,FF,00 with one step per 2 clk.
  - OVF=1 at the FF->00 edge.
  - TCR reads 'h04.
- Ch1: TDR='h01, TCR='h07 (load, down, enable), CKS=0:
  - TCNT counts 01,00,FF.
  - UDF=1.
  - Writing TSR='h02 clears UDF; writing 'h00 leaves it set.
- Same-edge conflict: issue W1C to TSR.OVF on the edge where a wrap occurs -> OVF reads 1. With TIMER_MC_IRQ_EN and OVF_IE=1 -> irq[0] rises one clk after the flag.
- Assert rst mid-count with TCNT='h80 -> TCNT, TSR, TCR = 0 immediately. irq=0. After release, no counting until EN is written.
